// File: rtl/fle_serial_addsub.sv
// Bit-serial add/subtract engine.
// A single full-adder cell with a registered carry walks the operands LSB
// first, one bit per clock. Subtraction is A + ~B + 1: B is inverted at load
// time and the carry is preset to 1. After the last bit, one more edge copies
// the finished sum and flags into the output registers. Those registers stay
// stable for as long as the result handshake is pending.
module fle_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf
);

  // Counter runs 0..WIDTH: values below WIDTH are bit steps, and WIDTH is the publish step.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic             sub_reg;
  logic             c_msb_reg;
  logic [CW-1:0]    cnt_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_result_reg;
  logic             out_carry_reg;
  logic             out_ovf_reg;

  logic fa_s;
  logic fa_co;

  // The one full-adder slice, fed by the LSBs of the shift registers.
  always_comb begin
    fa_s  = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
    fa_co = (a_sh_reg[0] & b_sh_reg[0]) |
            (a_sh_reg[0] & carry_reg)   |
            (b_sh_reg[0] & carry_reg);
  end

  // Control FSM plus datapath. Every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      res_reg        <= '0;
      carry_reg      <= 1'b0;
      sub_reg        <= 1'b0;
      c_msb_reg      <= 1'b0;
      cnt_reg        <= '0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_carry_reg  <= 1'b0;
      out_ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg     <= in_a;
            b_sh_reg     <= in_b ^ {WIDTH{in_sub}};
            carry_reg    <= in_sub;
            sub_reg      <= in_sub;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          if (cnt_reg == CW'(WIDTH)) begin
            // Every bit is processed, so publish the result and flags.
            out_result_reg <= res_reg;
            out_carry_reg  <= carry_reg ^ sub_reg;
            out_ovf_reg    <= carry_reg ^ c_msb_reg;
            out_valid_reg  <= 1'b1;
            state_reg      <= DONE;
          end else begin
            res_reg   <= {fa_s, res_reg[WIDTH-1:1]};
            a_sh_reg  <= a_sh_reg >> 1;
            b_sh_reg  <= b_sh_reg >> 1;
            carry_reg <= fa_co;
            if (cnt_reg == CW'(WIDTH - 1)) begin
              // Carry into the sign bit, needed for signed overflow.
              c_msb_reg <= carry_reg;
            end
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_carry  = out_carry_reg;
  assign out_ovf    = out_ovf_reg;

endmodule

// File: tb/tb_fle_serial_addsub.sv
// Self-checking bench for fle_serial_addsub (WIDTH=8).
// An arithmetic reference model predicts the handshake timing and the result
// of every operation, and a negedge monitor compares the DUT against it on
// every cycle. Directed operations also check hand-computed literal values.
module tb_fle_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cur_acc = 0;
  int last_acc = 0;

  fle_serial_addsub #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer add/sub, then range tests.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 output logic [W-1:0] r, output logic c, output logic o);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua < ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur >= (1 << W));
    end
    r = ur[W-1:0];
    o = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
  endfunction

  // Timing model: an accept is followed by W+1 busy edges, then the result
  // is held until out_ready.
  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;
  int           m_state = M_IDLE;
  int           m_cnt = 0;
  bit           m_zero = 1'b1;
  bit           chk_en = 1'b0;
  logic [W-1:0] m_r = '0;
  logic         m_c = 1'b0;
  logic         m_o = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] r;
    logic c, o;
    if (reset) begin
      chk_en  <= 1'b1;
      m_state <= M_IDLE;
      m_zero  <= 1'b1;
    end else begin
      case (m_state)
        M_IDLE: if (in_valid) begin
          ref_op(in_a, in_b, in_sub, r, c, o);
          m_r     <= r;
          m_c     <= c;
          m_o     <= o;
          m_cnt   <= W + 1;
          m_zero  <= 1'b0;
          m_state <= M_BUSY;
        end
        M_BUSY: begin
          if (m_cnt == 1) m_state <= M_DONE;
          m_cnt <= m_cnt - 1;
        end
        default: if (out_ready) m_state <= M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_state == M_IDLE));
      chk("out_valid", 32'(out_valid), 32'(m_state == M_DONE));
      if (m_state == M_DONE) begin
        chk("result", 32'(out_result), 32'(m_r));
        chk("carry", 32'(out_carry), 32'(m_c));
        chk("ovf", 32'(out_ovf), 32'(m_o));
      end else if (m_zero) begin
        chk("reset_result", 32'(out_result), 32'(0));
        chk("reset_carry", 32'(out_carry), 32'(0));
        chk("reset_ovf", 32'(out_ovf), 32'(0));
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit keep);
    bit ok;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_seen", 32'(ok), 32'(1));
    @(posedge clk);
    #1;
    last_acc = cur_acc;
    cur_acc  = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] er, input logic ec, input logic eo);
    int k;
    out_ready = 1'b1;
    send(a, b, sub, 1'b0);
    wait_valid(k);
    chk({name, "_latency"}, 32'(k), 32'(W + 1));
    chk({name, "_result"}, 32'(out_result), 32'(er));
    chk({name, "_carry"}, 32'(out_carry), 32'(ec));
    chk({name, "_ovf"}, 32'(out_ovf), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    bit seen;
    logic [W-1:0] ra, rb;
    logic rs;

    // Reset for two cycles, then sit idle.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_ready", 32'(in_ready), 32'(1));

    // Directed operations with literal expectations.
    run_op("sub_5_3", 8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1'b0);
    run_op("sub_3_5", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("sub_0_0", 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);

    // Backpressure: hold the result while a new request is pending.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 1'b0);
    wait_valid(k);
    chk("bp_latency", 32'(k), 32'(W + 1));
    in_a     = 8'hAA;
    in_b     = 8'h11;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(out_valid), 32'(1));
      chk("bp_ready", 32'(in_ready), 32'(0));
      chk("bp_result", 32'(out_result), 32'(8'h46));
      chk("bp_carry", 32'(out_carry), 32'(0));
      chk("bp_ovf", 32'(out_ovf), 32'(0));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(out_valid), 32'(0));
    chk("bp_release_ready", 32'(in_ready), 32'(1));

    // Reset in the middle of RUN discards the operation.
    send(8'h55, 8'h2A, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_run_ready", 32'(in_ready), 32'(1));
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_run_no_valid", 32'(seen), 32'(0));
    run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0);

    // Back-to-back random traffic with both handshakes held open.
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, 1'b1);
      if (i > 0) chk("accept_spacing", 32'(cur_acc - last_acc), 32'(W + 3));
    end
    in_valid = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
